// File: rtl/mem_bus_responder_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_bus_responder_pkg
// Description : Shared constants for the SRP16 memory-side responder.
//               Contains the bus widths, the FSM state encodings (2-bit),
//               the default I/O page and the I/O page decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_responder_pkg;

    localparam int c_ADDR_W = 16;
    localparam int c_DATA_W = 16;
    localparam int c_BYTE_W = 8;
    localparam int c_CNT_W  = 4;

    localparam logic [c_BYTE_W-1:0] c_IO_PAGE_DEFAULT = 8'hFF;

    // Responder FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_SWAIT  = 2'd1;
    localparam state_t c_ST_IOWAIT = 2'd2;
    localparam state_t c_ST_DONE   = 2'd3;

    // The high address byte selects the memory-mapped I/O page.
    function automatic logic is_io_page(input logic [c_ADDR_W-1:0] addr,
                                        input logic [c_BYTE_W-1:0] page);
        return (addr[c_ADDR_W-1:c_BYTE_W] == page);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_bus_responder
// Description : Services the SRP16 control unit's mem_read/mem_write strobes
//               against a byte-wide synchronous SRAM or a memory-mapped I/O
//               page, with configurable SRAM wait states and an I/O ack
//               timeout. Completion is a one-cycle ready pulse.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               abus, din          - core address / data (din[7:0] = byte)
//               mem_read/mem_write - request strobes, held until ready
//               dout, dout_en      - read data {8'h00,byte} and its enable
//               ready, bus_err     - completion pulse, sticky error flag
//               sram_*             - SRAM address/data/enable/write enable
//               io_*               - I/O index/data/strobes/ack
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned    WAIT_STATES = 1,   // 0..15
    parameter logic [7:0]     IO_PAGE     = c_IO_PAGE_DEFAULT,
    parameter int unsigned    IO_TIMEOUT  = 15   // 1..16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [c_ADDR_W-1:0]  abus,
    input  logic [c_DATA_W-1:0]  din,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic [c_DATA_W-1:0]  dout,
    output logic                 dout_en,
    output logic                 ready,
    output logic                 bus_err,
    output logic [c_ADDR_W-1:0]  sram_addr,
    output logic [c_BYTE_W-1:0]  sram_wdata,
    input  logic [c_BYTE_W-1:0]  sram_rdata,
    output logic                 sram_en,
    output logic                 sram_we,
    output logic [c_BYTE_W-1:0]  io_addr,
    output logic [c_BYTE_W-1:0]  io_wdata,
    input  logic [c_BYTE_W-1:0]  io_rdata,
    output logic                 io_re,
    output logic                 io_we,
    input  logic                 io_ack
);

    // The shared counter counts down to zero; the I/O timeout therefore
    // loads one less than the number of IOWAIT cycles allowed.
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_CNT_W'(WAIT_STATES);
    localparam logic [c_CNT_W-1:0] c_TMO_LOAD  = c_CNT_W'(IO_TIMEOUT - 1);

    state_t               r_state,      w_state;
    logic [c_CNT_W-1:0]   r_cnt,        w_cnt;
    logic                 r_is_read,    w_is_read;
    logic [c_DATA_W-1:0]  r_dout,       w_dout;
    logic                 r_dout_en,    w_dout_en;
    logic                 r_ready,      w_ready;
    logic                 r_bus_err,    w_bus_err;
    logic [c_ADDR_W-1:0]  r_sram_addr,  w_sram_addr;
    logic [c_BYTE_W-1:0]  r_sram_wdata, w_sram_wdata;
    logic                 r_sram_en,    w_sram_en;
    logic                 r_sram_we,    w_sram_we;
    logic [c_BYTE_W-1:0]  r_io_addr,    w_io_addr;
    logic [c_BYTE_W-1:0]  r_io_wdata,   w_io_wdata;
    logic                 r_io_re,      w_io_re;
    logic                 r_io_we,      w_io_we;

    // Only the low byte of the core data bus is ever written.
    logic w_unused_din_hi;
    assign w_unused_din_hi = ^din[c_DATA_W-1:c_BYTE_W];

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // Pulsed outputs default low; addresses/data hold their last value.
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_is_read    = r_is_read;
        w_dout       = '0;
        w_dout_en    = 1'b0;
        w_ready      = 1'b0;
        w_bus_err    = r_bus_err;
        w_sram_addr  = r_sram_addr;
        w_sram_wdata = r_sram_wdata;
        w_sram_en    = r_sram_en;
        w_sram_we    = 1'b0;
        w_io_addr    = r_io_addr;
        w_io_wdata   = r_io_wdata;
        w_io_re      = 1'b0;
        w_io_we      = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (mem_read && mem_write) begin
                    // Conflicting strobes: refuse the access, complete at once.
                    w_bus_err = 1'b1;
                    w_ready   = 1'b1;
                    w_state   = c_ST_DONE;
                end else if (mem_read || mem_write) begin
                    w_is_read = mem_read;
                    if (is_io_page(abus, IO_PAGE)) begin
                        w_io_addr  = abus[c_BYTE_W-1:0];
                        w_io_wdata = din[c_BYTE_W-1:0];
                        w_io_re    = mem_read;
                        w_io_we    = mem_write;
                        w_cnt      = c_TMO_LOAD;
                        w_state    = c_ST_IOWAIT;
                    end else begin
                        w_sram_en    = 1'b1;
                        w_sram_addr  = abus;
                        w_sram_we    = mem_write;
                        w_sram_wdata = din[c_BYTE_W-1:0];
                        w_cnt        = c_WAIT_LOAD;
                        w_state      = c_ST_SWAIT;
                    end
                end
            end

            c_ST_SWAIT: begin
                if (r_cnt == '0) begin
                    w_sram_en = 1'b0;
                    w_ready   = 1'b1;
                    w_dout_en = r_is_read;
                    if (r_is_read) begin
                        w_dout = {{(c_DATA_W-c_BYTE_W){1'b0}}, sram_rdata};
                    end
                    w_state = c_ST_DONE;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end

            c_ST_IOWAIT: begin
                // An ack on the final allowed cycle still wins over timeout.
                if (io_ack) begin
                    w_ready   = 1'b1;
                    w_dout_en = r_is_read;
                    if (r_is_read) begin
                        w_dout = {{(c_DATA_W-c_BYTE_W){1'b0}}, io_rdata};
                    end
                    w_state = c_ST_DONE;
                end else if (r_cnt == '0) begin
                    w_ready   = 1'b1;
                    w_bus_err = 1'b1;
                    w_dout_en = r_is_read;
                    if (r_is_read) begin
                        w_dout = {{(c_DATA_W-c_BYTE_W){1'b0}}, 8'hFF};
                    end
                    w_state = c_ST_DONE;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end

            // Ready is high during this cycle. Strobes are not sampled here,
            // so a strobe still held from the finished access is not repeated.
            c_ST_DONE: begin
                w_state = c_ST_IDLE;
            end

            default: begin
                w_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_is_read    <= 1'b0;
            r_dout       <= '0;
            r_dout_en    <= 1'b0;
            r_ready      <= 1'b0;
            r_bus_err    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_io_addr    <= '0;
            r_io_wdata   <= '0;
            r_io_re      <= 1'b0;
            r_io_we      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_is_read    <= w_is_read;
            r_dout       <= w_dout;
            r_dout_en    <= w_dout_en;
            r_ready      <= w_ready;
            r_bus_err    <= w_bus_err;
            r_sram_addr  <= w_sram_addr;
            r_sram_wdata <= w_sram_wdata;
            r_sram_en    <= w_sram_en;
            r_sram_we    <= w_sram_we;
            r_io_addr    <= w_io_addr;
            r_io_wdata   <= w_io_wdata;
            r_io_re      <= w_io_re;
            r_io_we      <= w_io_we;
        end
    end

    assign dout       = r_dout;
    assign dout_en    = r_dout_en;
    assign ready      = r_ready;
    assign bus_err    = r_bus_err;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;
    assign sram_en    = r_sram_en;
    assign sram_we    = r_sram_we;
    assign io_addr    = r_io_addr;
    assign io_wdata   = r_io_wdata;
    assign io_re      = r_io_re;
    assign io_we      = r_io_we;

endmodule
`default_nettype wire
